// File: rtl/scmi_sched_pkg.sv
// Shared types and width helpers for the SCMI doorbell scheduler.
package scmi_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } sched_state_e;

  localparam int unsigned NumChannelsDefault   = 4;
  localparam int unsigned TimeoutCyclesDefault = 1024;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must be able to hold the value t.
  function automatic int unsigned cnt_width(input int unsigned t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

  localparam int unsigned ChanIdxWDefault = idx_width(NumChannelsDefault);
  localparam int unsigned CntWDefault     = cnt_width(TimeoutCyclesDefault);

  typedef logic [ChanIdxWDefault-1:0] chan_idx_t;

endpackage

// File: rtl/scmi_rr_picker.sv
// Combinational round-robin pick: first pending channel strictly after
// the last-grant pointer, wrapping modulo the channel count.
module scmi_rr_picker
  import scmi_sched_pkg::*;
#(
  parameter int unsigned NumChannels = NumChannelsDefault,
  parameter int unsigned ChanIdxW    = idx_width(NumChannels)
) (
  input  logic [NumChannels-1:0] pending,
  input  logic [ChanIdxW-1:0]    last,
  output logic                   valid,
  output logic [ChanIdxW-1:0]    idx
);

  logic [ChanIdxW-1:0] pos;

  // Scan from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop; otherwise an
    // iteration that never hits would leave it unassigned and infer a latch.
    valid = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = NumChannels; k >= 1; k--) begin
      pos = ChanIdxW'((int'(last) + k) % NumChannels);
      if (pending[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/scmi_doorbell_scheduler.sv
// Shares the single SCMI platform agent between several mailbox channels:
// round-robin grant of pending doorbells, one non-preemptive service at a
// time, completion or timeout reported back per channel.
module scmi_doorbell_scheduler
  import scmi_sched_pkg::*;
#(
  parameter int unsigned NumChannels   = NumChannelsDefault,
  parameter int unsigned TimeoutCycles = TimeoutCyclesDefault,
  parameter int unsigned ChanIdxW      = idx_width(NumChannels)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumChannels-1:0] doorbell_i,
  output logic [NumChannels-1:0] doorbell_clr_o,
  output logic                   irq_ibex_o,
  output logic [ChanIdxW-1:0]    chan_id_o,
  input  logic                   ack_i,
  output logic [NumChannels-1:0] irq_agent_o,
  input  logic [NumChannels-1:0] agent_clr_i,
  output logic [NumChannels-1:0] timeout_o,
  output logic                   busy_o
);

  localparam int unsigned          CntW      = cnt_width(TimeoutCycles);
  localparam bit                   TimeoutEn = (TimeoutCycles != 0);
  localparam logic [CntW-1:0]      CntMax    = CntW'(TimeoutCycles);
  localparam logic [CntW-1:0]      CntLast   = CntW'(TimeoutEn ? TimeoutCycles - 1 : 0);
  localparam logic [NumChannels-1:0] OneHot0 = NumChannels'(1);
  localparam logic [ChanIdxW-1:0]  PtrInit   = ChanIdxW'(NumChannels - 1);

  sched_state_e          state_q, state_d;
  logic [ChanIdxW-1:0]   ptr_q;       // last grant; also the channel in service
  logic [CntW-1:0]       cnt_q;
  logic [NumChannels-1:0] clr_q;
  logic [NumChannels-1:0] agent_q;
  logic [NumChannels-1:0] tmo_q;

  logic                   pick_valid;
  logic [ChanIdxW-1:0]    pick_idx;
  logic [NumChannels-1:0] pending;
  logic                   grant;
  logic                   ack_fire;
  logic                   tmo_fire;
  logic [NumChannels-1:0] served_oh;

  // A channel with an unread result (completion or timeout) is held off.
  assign pending   = doorbell_i & ~agent_q & ~tmo_q;
  assign served_oh = OneHot0 << ptr_q;

  scmi_rr_picker #(
    .NumChannels (NumChannels),
    .ChanIdxW    (ChanIdxW)
  ) u_picker (
    .pending (pending),
    .last    (ptr_q),
    .valid   (pick_valid),
    .idx     (pick_idx)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: grant from IDLE, leave SERVE on ack (priority) or timeout.
  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    ack_fire = 1'b0;
    tmo_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = SERVE;
          grant   = 1'b1;
        end
      end
      SERVE: begin
        if (ack_i) begin
          ack_fire = 1'b1;
          state_d  = IDLE;
        end else if (TimeoutEn && (cnt_q == CntLast)) begin
          tmo_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant pointer, service counter and the one-cycle doorbell clear pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= PtrInit;
      cnt_q <= '0;
      clr_q <= '0;
    end else begin
      clr_q <= grant ? (OneHot0 << pick_idx) : '0;
      if (grant) begin
        ptr_q <= pick_idx;
        cnt_q <= '0;
      end else if (state_q == SERVE && cnt_q != CntMax) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  // Per-channel result flags: a set in the same cycle as a clear wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      agent_q <= '0;
      tmo_q   <= '0;
    end else begin
      agent_q <= (ack_fire ? served_oh : '0) | (agent_q & ~agent_clr_i);
      tmo_q   <= (tmo_fire ? served_oh : '0) | (tmo_q & ~agent_clr_i);
    end
  end

  assign irq_ibex_o     = (state_q == SERVE);
  assign busy_o         = (state_q == SERVE);
  assign chan_id_o      = (state_q == SERVE) ? ptr_q : '0;
  assign doorbell_clr_o = clr_q;
  assign irq_agent_o    = agent_q;
  assign timeout_o      = tmo_q;

endmodule
